mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Sequences the single shared memory port between the instruction-fetch requester and the memory-stage data requester.
- Data side is driven by the decoder's memory control bits: [0] read, [1] write, [2] push, [3] pop, [4] ldd, [5] std.
- Owns the stack pointer and generates push/pop addresses.
- Stalls fetch while a data access holds the port.

Parameters:
- ADDR_W, 16, memory word-address width and SP width
- DATA_W, 16, memory word width
- SP_INIT, 16'hFFFF, SP value after reset (top of stack, word address)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous active-high reset
- if_req  in  1  fetch requests one instruction word; level, held until if_valid
- if_addr  in  ADDR_W  fetch address, sampled when the request is accepted
- if_data  out  DATA_W  fetched word, valid only while if_valid=1
- if_valid  out  1  one-cycle pulse, fetch complete
- stall  out  1  fetch is pending and not being served this cycle
- mem_req  in  1  data access request; level, held until mem_done or mem_err
- mem_ctrl  in  6  decoded memory control bits, bit map as in Overview
- mem_ea  in  ADDR_W  effective address for ldd/std
- mem_wdata  in  DATA_W  store/push data
- mem_rdata  out  DATA_W  load/pop result, valid only while mem_done=1
- mem_done  out  1  one-cycle pulse, data access complete
- mem_err  out  1  one-cycle pulse, illegal mem_ctrl rejected
- sp  out  ADDR_W  current stack pointer
- ram_en  out  1  memory access strobe
- ram_we  out  1  1 = write, 0 = read; qualified by ram_en
- ram_addr  out  ADDR_W  memory address
- ram_wdata  out  DATA_W  memory write data
- ram_rdata  in  DATA_W  memory read data, valid with ram_ack
- ram_ack  in  1  memory completes the current access; may arrive in the first cycle ram_en is high

Behaviour:
- Reset (async, immediate):
  - State IDLE; sp=SP_INIT.
  - All other outputs 0: ram_en, ram_we, if_valid, mem_done, mem_err, stall, if_data, mem_rdata, ram_addr, ram_wdata.
  - Any in-flight access is abandoned. No done/valid pulse is produced for it, and SP is not updated.
- States: IDLE, FETCH, DATA. All outputs are registered.
- IDLE:
  - mem_req=1 with legal ctrl -> latch ctrl/address/wdata, go to DATA.
  - Else if_req=1 -> latch if_addr, go to FETCH.
  - Data has fixed priority over fetch when both are requested.
  - mem_req=1 with illegal ctrl -> mem_err pulses the next cycle; stay IDLE; no memory access; SP unchanged. The fetch request is not served in that cycle.
- Legal ctrl (exactly one of [5:2] set, plus the matching direction bit):
  - push: ctrl[2] and ctrl[1]; [0]=0.
  - std: ctrl[5] and ctrl[1]; [0]=0.
  - pop: ctrl[3] and ctrl[0]; [1]=0.
  - ldd: ctrl[4] and ctrl[0]; [1]=0.
  - Every other combination is illegal, including all-zero.
- Addresses:
  - push: ram_addr=sp, we=1, post-decrement (sp <= sp-1 on completion).
  - pop: ram_addr=sp+1, we=0, pre-increment (sp <= sp+1 on completion).
  - ldd: ram_addr=mem_ea, we=0.
  - std: ram_addr=mem_ea, we=1.
  - fetch: ram_addr=if_addr, we=0.
  - All address arithmetic wraps modulo 2^ADDR_W with no flag.
- FETCH/DATA:
  - ram_en=1 with ram_we/addr/wdata stable for every cycle in the state.
  - On the first clock edge where ram_ack=1:
    - go to IDLE; ram_en falls;
    - FETCH: capture ram_rdata into if_data and pulse if_valid;
    - DATA: capture reads into mem_rdata, pulse mem_done, update sp.
  - Minimum latency: request seen in cycle 0, ram_en high in cycle 1, ack in cycle 1, done/valid high in cycle 2.
  - Back-to-back accesses are not allowed: at least one IDLE cycle follows every completion, and ram_en is low in that cycle.
- stall is 1 in any cycle where if_req=1 and the block is neither in FETCH nor pulsing if_valid. It is 0 otherwise.
- Requests changing while in FETCH/DATA are ignored; the latched values are used.

Test Plan:
- Reset: rst=1 mid-FETCH with ram_en=1 -> ram_en=0 immediately; after release sp=16'hFFFF; no if_valid pulse.
- Push then pop:
  - push of 16'hA5A5 -> write at addr FFFF; sp=FFFE after mem_done.
  - pop -> read at addr FFFF; mem_rdata=16'hA5A5; sp=FFFF.
- Contention: if_req and mem_req (ldd, ea=0x0040) raised in the same cycle:
  - ldd is served first; stall=1 throughout the ldd.
  - fetch starts after one IDLE cycle; if_valid follows.
- Wait states: std ea=0x1234, data=0xBEEF, ram_ack delayed 3 cycles -> ram_en/we/addr/wdata stable for 4 cycles; mem_done pulses exactly once.
- Illegal ctrl 6'b001100 (push+pop) and 6'b000000:
  - mem_err pulses once each;
  - ram_en stays 0; sp unchanged.
- Wrap: sp forced to 0 via 65535 pushes (or SP_INIT=0), then push -> address 0000 written; sp becomes FFFF.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - fetch, data-request and memory-port signals of the port arbiter
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_data;
    logic              if_valid;
    logic              stall;
    logic              mem_req;
    logic [5:0]        mem_ctrl;
    logic [ADDR_W-1:0] mem_ea;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_done;
    logic              mem_err;
    logic [ADDR_W-1:0] sp;
    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;
    logic              ram_ack;

    // slave is the arbiter's view; master is the surrounding core and memory
    modport slave (
        input  if_req, if_addr, mem_req, mem_ctrl, mem_ea, mem_wdata, ram_rdata, ram_ack,
        output if_data, if_valid, stall, mem_rdata, mem_done, mem_err, sp,
               ram_en, ram_we, ram_addr, ram_wdata
    );

    modport master (
        output if_req, if_addr, mem_req, mem_ctrl, mem_ea, mem_wdata, ram_rdata, ram_ack,
        input  if_data, if_valid, stall, mem_rdata, mem_done, mem_err, sp,
               ram_en, ram_we, ram_addr, ram_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between instruction fetch and data access, owns SP
module mem_port_arbiter #(
    parameter int                ADDR_W  = 16,
    parameter int                DATA_W  = 16,
    parameter logic [ADDR_W-1:0] SP_INIT = '1
) (
    input  logic                clk,
    input  logic                rst,
    mem_port_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, FETCH, DATA} state_t;

    state_t state;
    logic   op_push;
    logic   op_pop;

    logic is_push, is_pop, is_ldd, is_std, legal;
    logic mem_go, fetch_go;

    always_comb begin
        is_push  = (bus.mem_ctrl == 6'b000110);
        is_std   = (bus.mem_ctrl == 6'b100010);
        is_pop   = (bus.mem_ctrl == 6'b001001);
        is_ldd   = (bus.mem_ctrl == 6'b010001);
        legal    = is_push | is_std | is_pop | is_ldd;
        // A requester may still hold its level in the cycle its done/err/valid pulse is visible
        mem_go   = bus.mem_req && !bus.mem_done && !bus.mem_err;
        fetch_go = bus.if_req && !bus.if_valid;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            op_push       <= 1'b0;
            op_pop        <= 1'b0;
            bus.sp        <= SP_INIT;
            bus.ram_en    <= 1'b0;
            bus.ram_we    <= 1'b0;
            bus.ram_addr  <= '0;
            bus.ram_wdata <= '0;
            bus.if_data   <= '0;
            bus.if_valid  <= 1'b0;
            bus.mem_rdata <= '0;
            bus.mem_done  <= 1'b0;
            bus.mem_err   <= 1'b0;
            bus.stall     <= 1'b0;
        end else begin
            bus.if_valid <= 1'b0;
            bus.mem_done <= 1'b0;
            bus.mem_err  <= 1'b0;
            case (state)
                IDLE: begin
                    bus.stall <= bus.if_req;
                    if (mem_go && legal) begin
                        state         <= DATA;
                        op_push       <= is_push;
                        op_pop        <= is_pop;
                        bus.ram_en    <= 1'b1;
                        bus.ram_we    <= is_push | is_std;
                        bus.ram_addr  <= is_push ? bus.sp :
                                         is_pop  ? bus.sp + ADDR_W'(1) : bus.mem_ea;
                        bus.ram_wdata <= bus.mem_wdata;
                    end else if (mem_go) begin
                        bus.mem_err <= 1'b1;
                    end else if (fetch_go) begin
                        state        <= FETCH;
                        bus.ram_en   <= 1'b1;
                        bus.ram_we   <= 1'b0;
                        bus.ram_addr <= bus.if_addr;
                        bus.stall    <= 1'b0;
                    end
                end
                FETCH: begin
                    bus.stall <= 1'b0;
                    if (bus.ram_ack) begin
                        state        <= IDLE;
                        bus.ram_en   <= 1'b0;
                        bus.if_data  <= bus.ram_rdata;
                        bus.if_valid <= 1'b1;
                    end
                end
                DATA: begin
                    bus.stall <= bus.if_req;
                    if (bus.ram_ack) begin
                        state        <= IDLE;
                        bus.ram_en   <= 1'b0;
                        bus.mem_done <= 1'b1;
                        if (!bus.ram_we)
                            bus.mem_rdata <= bus.ram_rdata;
                        if (op_push)
                            bus.sp <= bus.sp - ADDR_W'(1);
                        else if (op_pop)
                            bus.sp <= bus.sp + ADDR_W'(1);
                    end
                end
                default: begin
                    state      <= IDLE;
                    bus.ram_en <= 1'b0;
                end
            endcase
        end
    end
endmodule
